// File: rtl/spi_arbiter.sv
// spi_arbiter
//   Shares one spi_master between N_REQ word-stream requesters. Grants the
//   bus round-robin per transaction, drives one active-low chip select per
//   requester with programmable setup/hold/gap times, forwards transmit
//   words to the master and routes received words back to the owner.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/last/data      per-requester word stream (data packed by index)
//   req_ready                combinational accept for the granted requester
//   rsp_valid, rsp_data      per-requester response pulse, shared data word
//   grant, ss_n              one-hot owner and active-low chip selects
//   spi_valid_out/data_out   start pulse and transmit word to the master
//   spi_ready_in             master idle
//   spi_valid_in/data_in     master finished a word, received data
//
// State | meaning
// IDLE  | no owner, arbitrating among req_valid
// SETUP | chip select low, waiting SS_SETUP cycles
// SEND  | offering req_ready to the owner
// WAIT  | word in flight, waiting for spi_valid_in
// HOLD  | last word answered, waiting SS_HOLD cycles
// GAP   | chip select high, waiting SS_GAP cycles
module spi_arbiter #(
  parameter int DATA_BITS = 8,
  parameter int N_REQ     = 2,
  parameter int SS_SETUP  = 2,
  parameter int SS_HOLD   = 2,
  parameter int SS_GAP    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*DATA_BITS-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DATA_BITS-1:0]       rsp_data,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           ss_n,
  output logic                       spi_valid_out,
  output logic [DATA_BITS-1:0]       spi_data_out,
  input  logic                       spi_ready_in,
  input  logic                       spi_valid_in,
  input  logic [DATA_BITS-1:0]       spi_data_in
);

  localparam int T_MAX = (SS_SETUP > SS_HOLD)
                         ? ((SS_SETUP > SS_GAP) ? SS_SETUP : SS_GAP)
                         : ((SS_HOLD > SS_GAP) ? SS_HOLD : SS_GAP);
  localparam int CW = $clog2(T_MAX + 1);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, HOLD, GAP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        g_idx;
  logic                 last_q;

  logic                 pick_any;
  logic [PW-1:0]        pick_idx;
  logic [N_REQ-1:0]     pick_onehot;
  logic [PW-1:0]        next_ptr;
  logic                 accept;
  logic [DATA_BITS-1:0] word_sel;

  // Scan downward so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    int idx;
    logic [PW-1:0] cand;
    pick_any = 1'b0;
    pick_idx = '0;
    idx      = 0;
    cand     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx  = (int'(rr_ptr) + i) % N_REQ;
      cand = PW'(idx);
      if (req_valid[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_onehot = N_REQ'(1) << pick_idx;
  assign next_ptr    = PW'((int'(pick_idx) + 1) % N_REQ);

  assign req_ready = (state == SEND) ? (grant & {N_REQ{spi_ready_in}}) : '0;
  assign accept    = (state == SEND) && spi_ready_in && req_valid[g_idx];
  assign word_sel  = req_data[int'(g_idx)*DATA_BITS +: DATA_BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rr_ptr        <= '0;
      g_idx         <= '0;
      last_q        <= 1'b0;
      grant         <= '0;
      ss_n          <= '1;
      spi_valid_out <= 1'b0;
      spi_data_out  <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
    end else begin
      spi_valid_out <= 1'b0;
      rsp_valid     <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant  <= pick_onehot;
            ss_n   <= ~pick_onehot;
            g_idx  <= pick_idx;
            rr_ptr <= next_ptr;
            cnt    <= CW'(SS_SETUP);
            state  <= SETUP;
          end
        end
        SETUP: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) state <= SEND;
        end
        SEND: begin
          if (accept) begin
            spi_data_out  <= word_sel;
            spi_valid_out <= 1'b1;
            last_q        <= req_last[g_idx];
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (spi_valid_in) begin
            rsp_data  <= spi_data_in;
            rsp_valid <= grant;
            if (last_q) begin
              cnt   <= CW'(SS_HOLD);
              state <= HOLD;
            end else begin
              state <= SEND;
            end
          end
        end
        HOLD: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) begin
            ss_n  <= '1;
            grant <= '0;
            cnt   <= CW'(SS_GAP);
            state <= GAP;
          end
        end
        GAP: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter
//   Directed bench for spi_arbiter with default parameters (8-bit words,
//   two requesters, setup 2, hold 2, gap 1). Inputs change and outputs are
//   observed on the falling clock edge.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  grant;
  logic [1:0]  ss_n;
  logic        spi_valid_out;
  logic [7:0]  spi_data_out;
  logic        spi_ready_in;
  logic        spi_valid_in;
  logic [7:0]  spi_data_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .grant(grant), .ss_n(ss_n),
    .spi_valid_out(spi_valid_out), .spi_data_out(spi_data_out),
    .spi_ready_in(spi_ready_in), .spi_valid_in(spi_valid_in),
    .spi_data_in(spi_data_in)
  );

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    spi_ready_in = 1'b1; spi_valid_in = 1'b0; spi_data_in = '0;
    repeat (2) @(negedge clk);
    checks++; if (ss_n !== 2'b11) begin errors++; $display("FAIL reset_ss_n got %b exp 11", ss_n); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    checks++; if (spi_valid_out !== 1'b0) begin errors++; $display("FAIL reset_spi_valid_out got %b exp 0", spi_valid_out); end
    checks++; if (spi_data_out !== 8'h00) begin errors++; $display("FAIL reset_spi_data_out got %h exp 00", spi_data_out); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h exp 00", rsp_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_data[7:0] = 8'h9F; req_last = 2'b00;
    @(negedge clk); // t+1
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", grant); end
    checks++; if (ss_n !== 2'b10) begin errors++; $display("FAIL single_ss_low got %b exp 10", ss_n); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_t1 got %b exp 00", req_ready); end
    @(negedge clk); // t+2
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_t2 got %b exp 00", req_ready); end
    @(negedge clk); // t+3, SEND
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready_t3 got %b exp 01", req_ready); end
    @(negedge clk);
    checks++; if (spi_valid_out !== 1'b1 || spi_data_out !== 8'h9F) begin errors++; $display("FAIL single_tx0 got %b/%h exp 1/9f", spi_valid_out, spi_data_out); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_wait got %b exp 00", req_ready); end
    req_data[7:0] = 8'h00; req_last = 2'b01;
    @(negedge clk);
    checks++; if (spi_valid_out !== 1'b0 || spi_data_out !== 8'h9F) begin errors++; $display("FAIL single_tx0_pulse got %b/%h exp 0/9f", spi_valid_out, spi_data_out); end
    spi_valid_in = 1'b1; spi_data_in = 8'h58;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h58) begin errors++; $display("FAIL single_rsp0 got %b/%h exp 01/58", rsp_valid, rsp_data); end
    spi_valid_in = 1'b0;
    @(negedge clk);
    checks++; if (spi_valid_out !== 1'b1 || spi_data_out !== 8'h00) begin errors++; $display("FAIL single_tx1 got %b/%h exp 1/00", spi_valid_out, spi_data_out); end
    req_valid = 2'b00; req_last = 2'b00;
    @(negedge clk); // cycle r
    spi_valid_in = 1'b1; spi_data_in = 8'hA5;
    @(negedge clk); // r+1
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 8'hA5) begin errors++; $display("FAIL single_rsp1 got %b/%h exp 01/a5", rsp_valid, rsp_data); end
    checks++; if (ss_n !== 2'b10) begin errors++; $display("FAIL single_hold1 got %b exp 10", ss_n); end
    spi_valid_in = 1'b0;
    @(negedge clk); // r+2
    checks++; if (ss_n !== 2'b10 || rsp_valid !== 2'b00) begin errors++; $display("FAIL single_hold2 got %b/%b exp 10/00", ss_n, rsp_valid); end
    @(negedge clk); // r+3
    checks++; if (ss_n !== 2'b11 || grant !== 2'b00) begin errors++; $display("FAIL single_release got %b/%b exp 11/00", ss_n, grant); end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int ngr = 0;
    logic [1:0] order [4];
    logic [1:0] prev_grant = 2'b00;
    int high_run = 0;
    int min_gap = 999;
    bit seen_low = 1'b0;
    int overlap = 0;
    int bad_data = 0;
    logic pend = 1'b0;
    for (int k = 0; k < 4; k++) order[k] = 2'b00;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req_valid = 2'b11; req_last = 2'b11; req_data = 16'h2211; spi_data_in = 8'h33;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      spi_valid_in = pend;
      pend = spi_valid_out;
      if (spi_valid_out && ((grant == 2'b01 && spi_data_out != 8'h11) ||
                            (grant == 2'b10 && spi_data_out != 8'h22))) bad_data++;
      if (ss_n == 2'b00) overlap++;
      if (ss_n == 2'b11) high_run++;
      else begin
        if (seen_low && high_run > 0 && high_run < min_gap) min_gap = high_run;
        high_run = 0;
        seen_low = 1'b1;
      end
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        if (ngr < 4) order[ngr] = grant;
        ngr++;
      end
      prev_grant = grant;
      if (ngr >= 4 && grant == 2'b00) break;
    end
    req_valid = 2'b00; req_last = 2'b00; spi_valid_in = 1'b0;
    checks++; if (ngr != 4) begin errors++; $display("FAIL fair_count got %0d exp 4", ngr); end
    checks++; if (order[0] !== 2'b01 || order[1] !== 2'b10 || order[2] !== 2'b01 || order[3] !== 2'b10)
      begin errors++; $display("FAIL fair_order got %b %b %b %b exp 01 10 01 10", order[0], order[1], order[2], order[3]); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL fair_overlap got %0d exp 0", overlap); end
    checks++; if (min_gap < 2) begin errors++; $display("FAIL fair_gap got %0d exp >=2", min_gap); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL fair_data got %0d bad exp 0", bad_data); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    bit ok;
    int viol = 0;
    req_valid = 2'b10; req_data[15:8] = 8'h3C; req_last = 2'b00;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (grant == 2'b10) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL stall_grant got %b exp 10", grant); end
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (req_ready == 2'b10) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL stall_ready got %b exp 10", req_ready); end
    @(negedge clk);
    checks++; if (spi_valid_out !== 1'b1 || spi_data_out !== 8'h3C) begin errors++; $display("FAIL stall_tx0 got %b/%h exp 1/3c", spi_valid_out, spi_data_out); end
    req_valid = 2'b00; spi_valid_in = 1'b1; spi_data_in = 8'h96;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== 8'h96) begin errors++; $display("FAIL stall_rsp0 got %b/%h exp 10/96", rsp_valid, rsp_data); end
    spi_valid_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ss_n !== 2'b01 || spi_valid_out !== 1'b0 || req_ready !== 2'b10) viol++;
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles exp 0", viol); end
    req_valid = 2'b10; req_data[15:8] = 8'hC3; req_last = 2'b10;
    @(negedge clk);
    checks++; if (spi_valid_out !== 1'b1 || spi_data_out !== 8'hC3) begin errors++; $display("FAIL stall_resume got %b/%h exp 1/c3", spi_valid_out, spi_data_out); end
    req_valid = 2'b00; req_last = 2'b00; spi_valid_in = 1'b1; spi_data_in = 8'h69;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== 8'h69) begin errors++; $display("FAIL stall_rsp1 got %b/%h exp 10/69", rsp_valid, rsp_data); end
    spi_valid_in = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (ss_n == 2'b11) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL stall_release got %b exp 11", ss_n); end
    @(negedge clk);
  endtask

  task automatic test_master_busy();
    bit ok;
    int viol = 0;
    spi_ready_in = 1'b0;
    req_valid = 2'b01; req_data[7:0] = 8'h5A; req_last = 2'b01;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (grant == 2'b01) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL busy_grant got %b exp 01", grant); end
    @(negedge clk); // t+2
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (req_ready !== 2'b00 || spi_valid_out !== 1'b0) viol++;
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL busy_stall got %0d bad cycles exp 0", viol); end
    spi_ready_in = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL busy_ready got %b exp 01", req_ready); end
    @(negedge clk);
    checks++; if (spi_valid_out !== 1'b1 || spi_data_out !== 8'h5A) begin errors++; $display("FAIL busy_tx got %b/%h exp 1/5a", spi_valid_out, spi_data_out); end
    req_valid = 2'b00; req_last = 2'b00; spi_valid_in = 1'b1; spi_data_in = 8'h77;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h77) begin errors++; $display("FAIL busy_rsp got %b/%h exp 01/77", rsp_valid, rsp_data); end
    spi_valid_in = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (ss_n == 2'b11) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL busy_release got %b exp 11", ss_n); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    req_valid = 2'b01; req_data[7:0] = 8'hE1; req_last = 2'b01;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (req_ready == 2'b01) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_ready got %b exp 01", req_ready); end
    @(negedge clk); // now in WAIT
    checks++; if (spi_valid_out !== 1'b1 || spi_data_out !== 8'hE1) begin errors++; $display("FAIL rstmid_tx got %b/%h exp 1/e1", spi_valid_out, spi_data_out); end
    req_valid = 2'b10; req_data[15:8] = 8'h4B; req_last = 2'b10;
    rst = 1'b1;
    #1;
    checks++; if (ss_n !== 2'b11 || grant !== 2'b00) begin errors++; $display("FAIL rstmid_async got %b/%b exp 11/00", ss_n, grant); end
    checks++; if (spi_valid_out !== 1'b0 || spi_data_out !== 8'h00) begin errors++; $display("FAIL rstmid_tx_clear got %b/%h exp 0/00", spi_valid_out, spi_data_out); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 2'b10 || ss_n !== 2'b01) begin errors++; $display("FAIL rstmid_regrant got %b/%b exp 10/01", grant, ss_n); end
    rst = 1'b1; req_valid = 2'b00; req_last = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray();
    spi_valid_in = 1'b1; spi_data_in = 8'hFF;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00 || rsp_data !== 8'h00 || grant !== 2'b00) begin errors++; $display("FAIL stray_idle got %b/%h/%b exp 00/00/00", rsp_valid, rsp_data, grant); end
    spi_valid_in = 1'b0;
    req_valid = 2'b01; req_data[7:0] = 8'h12; req_last = 2'b01;
    @(negedge clk); // t+1
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL stray_grant got %b exp 01", grant); end
    spi_valid_in = 1'b1;
    @(negedge clk); // t+2
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL stray_setup got %b/%b exp 00/00", rsp_valid, req_ready); end
    spi_valid_in = 1'b0;
    @(negedge clk); // t+3
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stray_send got %b exp 01", req_ready); end
    @(negedge clk);
    checks++; if (spi_valid_out !== 1'b1 || spi_data_out !== 8'h12) begin errors++; $display("FAIL stray_tx got %b/%h exp 1/12", spi_valid_out, spi_data_out); end
    req_valid = 2'b00; req_last = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_master_busy();
    test_reset_mid();
    test_stray();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
